signnarrow: RTL and testbench
=============================

Name: signnarrow

Overview:
- Streaming narrowing unit, the inverse of the sign-extension path. It takes M-bit two's-complement samples and produces N-bit samples.
- Out-of-range values are either saturated or wrapped, per sample.
- Sits between wide arithmetic datapaths and narrow storage or ports. It uses a valid/ready handshake with a 2-entry skid buffer, so the input-side ready is registered.
- Keeps a saturating count of out-of-range samples for status readout.

Parameters:
- N, 20, output width in bits; must satisfy N >= 2.
- M, 32, input width in bits; must satisfy M > N. Elaboration fails otherwise.
- CW, 16, width of the overflow event counter.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; asynchronous, active-high
- i_valid  input  1  input sample valid
- o_ready  output  1  block can accept a sample
- i_x  input  M  input sample, two's complement
- i_sat  input  1  per-sample mode: 1 = saturate, 0 = wrap (truncate); sampled with i_x
- o_valid  output  1  output sample valid
- i_ready  input  1  downstream accepts the output sample
- o_y  output  N  narrowed output sample
- o_ovf  output  1  the sample on o_y was out of range; qualified by o_valid
- i_clr_cnt  input  1  synchronous clear of the overflow counter
- o_ovf_cnt  output  CW  saturating count of accepted out-of-range samples

Behaviour:
- Reset (async assert, sync-released use): o_valid=0, o_y=0, o_ovf=0, skid empty, o_ready=1, o_ovf_cnt=0.
- Reset mid-stream drops both buffered entries; no output is produced for them.
- Fit check: a sample fits iff bits i_x[M-1:N-1] are all equal.
- Narrowing rules:
  - Fits: o_y = i_x[N-1:0], ovf=0.
  - Out of range, i_sat=1: o_y = {1'b0, {N-1{1'b1}}} if i_x[M-1]=0, else {1'b1, {N-1{1'b0}}}; ovf=1.
  - Out of range, i_sat=0: o_y = i_x[N-1:0]; ovf=1.
- Narrowing is computed combinationally on the input side and registered at acceptance. Stored entries hold {y, ovf}, never raw i_x.
- Input handshake: a sample is accepted when i_valid && o_ready. o_ready is a registered signal equal to "skid entry empty".
- Output handshake: a sample transfers when o_valid && i_ready.
- Latency: an accepted sample appears on o_y/o_valid the cycle after acceptance when the main register is free or draining. Zero bubbles at full throughput.
- Buffer operation per clock edge:
  - Main empty, or main transferring with skid empty: an accepted sample loads main.
  - Main full and not transferring: an accepted sample loads skid, and o_ready goes 0 next cycle.
  - Main transferring and skid full: skid moves to main, skid empties, o_ready goes 1 next cycle.
  - Skid full forces o_ready=0, so no acceptance can occur.
- While o_valid=1 && i_ready=0, o_y and o_ovf are held stable.
- Ordering is strictly FIFO; no sample is lost or duplicated.
- Counter:
  - Increments by 1 on each accepted sample whose ovf=1, counted at input acceptance.
  - Holds at all-ones (2^CW-1) and never wraps.
  - i_clr_cnt=1 sets the counter to 0 on the next edge. Clear has priority: a concurrent overflow acceptance is not counted.
- i_sat and i_x are don't-care when i_valid=0.

Decomposition:
- Package signnarrow_pkg holds:
  - the stored entry struct {y, ovf}, parameterised via localparams in the module;
  - a mode enum {NARROW_WRAP=0, NARROW_SAT=1} mapped onto i_sat.
- Sub-module sn_fit: combinational; ports i_x[M-1:0], i_sat, o_y[N-1:0], o_ovf. It contains the fit check and the saturate/wrap mux, and is unit-testable alone.
- Top level holds the skid buffer and the counter.

Test Plan (defaults N=20, M=32, i_ready=1 unless stated):
- Fits, positive and negative: i_x=32'h0007FFFF -> o_y=20'h7FFFF, o_ovf=0, one cycle later. i_x=32'hFFF80000 -> o_y=20'h80000, o_ovf=0. o_ovf_cnt stays 0.
- Saturate: i_sat=1, i_x=32'h00080000 -> o_y=20'h7FFFF, ovf=1. i_x=32'hFFF7FFFF -> o_y=20'h80000, ovf=1. o_ovf_cnt=2.
- Wrap: i_sat=0, i_x=32'h00080000 -> o_y=20'h80000, ovf=1. i_x=32'h12345678 -> o_y=20'h45678, ovf=1.
- Backpressure: stream 0,1,2,3,... with i_ready=0 for 3 cycles mid-stream.
  - o_ready drops one cycle after the second stalled acceptance.
  - o_y is held stable while stalled.
  - After release, the output sequence is exactly 0,1,2,3,... with no loss or duplicates.
  - Randomised i_valid/i_ready run is checked against a reference queue.
- Counter saturation and clear: CW=4 build, 20 overflow samples -> o_ovf_cnt=15. Assert i_clr_cnt in the same cycle as an overflow acceptance -> count=0.
- Async reset: assert i_rst with both entries full, between clock edges -> o_valid=0, o_ready=1, o_ovf_cnt=0 immediately. No stale output after release.

Source files
------------

// File: rtl/signnarrow_pkg.sv
//------------------------------------------------------------------------------
// signnarrow_pkg
// Shared types and helpers for the signnarrow streaming narrowing unit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package signnarrow_pkg;

  // Per-sample handling of values that do not fit the output width
  typedef enum logic {
    NARROW_WRAP = 1'b0,
    NARROW_SAT  = 1'b1
  } narrow_mode_e;

  // Map the raw i_sat pin onto the mode enum
  function automatic narrow_mode_e mode_of(input logic sat);
    return sat ? NARROW_SAT : NARROW_WRAP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sn_fit.sv
//------------------------------------------------------------------------------
// sn_fit
// Combinational fit check and saturate/wrap selection for one sample.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sn_fit
  import signnarrow_pkg::*;
#(
  parameter int N = 20,
  parameter int M = 32
) (
  input  logic [M-1:0] i_x,
  input  logic         i_sat,
  output logic [N-1:0] o_y,
  output logic         o_ovf
);

  // Width of the slice that must be all-equal for the value to fit
  localparam int TOPW = M - N + 1;

  localparam logic [N-1:0] C_POS_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] C_NEG_MIN = {1'b1, {(N-1){1'b0}}};

  logic [TOPW-1:0] w_top;
  logic            w_fits;

  assign w_top  = i_x[M-1:N-1];
  assign w_fits = (&w_top) | ~(|w_top);

  // Pass the low bits through unless saturation is requested for a misfit
  always_comb begin
    o_ovf = ~w_fits;
    o_y   = i_x[N-1:0];
    if (!w_fits && (mode_of(i_sat) == NARROW_SAT)) begin
      o_y = i_x[M-1] ? C_NEG_MIN : C_POS_MAX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/signnarrow.sv
//------------------------------------------------------------------------------
// signnarrow
// Streaming M-to-N bit two's-complement narrowing with saturate/wrap per
// sample, a 2-entry skid buffer (registered input ready) and a saturating
// overflow event counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module signnarrow
  import signnarrow_pkg::*;
#(
  parameter int N  = 20,
  parameter int M  = 32,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [M-1:0]  i_x,
  input  logic          i_sat,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [N-1:0]  o_y,
  output logic          o_ovf,
  input  logic          i_clr_cnt,
  output logic [CW-1:0] o_ovf_cnt
);

  generate
    if (!((N >= 2) && (M > N) && (CW >= 1))) begin : g_param_check
      $error("signnarrow: requires N >= 2, M > N and CW >= 1");
    end
  endgenerate

  // Buffered entries carry the already-narrowed result, never raw input
  typedef struct packed {
    logic [N-1:0] y;
    logic         ovf;
  } entry_t;

  localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};

  entry_t        w_new;
  entry_t        r_main;
  entry_t        r_skid;
  logic          r_main_v;
  logic          r_skid_v;
  logic          r_ready;
  logic          w_acc;
  logic          w_xfer;
  logic          w_main_free;
  logic [CW-1:0] r_cnt;

  sn_fit #(
    .N (N),
    .M (M)
  ) u_fit (
    .i_x   (i_x),
    .i_sat (i_sat),
    .o_y   (w_new.y),
    .o_ovf (w_new.ovf)
  );

  assign w_acc       = i_valid & r_ready;
  assign w_xfer      = r_main_v & i_ready;
  assign w_main_free = ~r_main_v | w_xfer;

  // Skid buffer: main feeds the output, skid absorbs one sample under stall
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_ready  <= 1'b1;
    end else if (w_main_free) begin
      if (r_skid_v) begin
        // Skid full implies no acceptance this cycle (ready was low)
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
        r_ready  <= 1'b1;
      end else if (w_acc) begin
        r_main   <= w_new;
        r_main_v <= 1'b1;
      end else begin
        r_main_v <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid   <= w_new;
      r_skid_v <= 1'b1;
      r_ready  <= 1'b0;
    end
  end

  // Overflow event counter: clear wins, sticks at all-ones
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_cnt <= '0;
    end else if (w_acc && w_new.ovf && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = r_main_v;
  assign o_y       = r_main.y;
  assign o_ovf     = r_main.ovf;
  assign o_ovf_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_signnarrow.sv
//------------------------------------------------------------------------------
// tb_signnarrow
// Directed self-checking bench for signnarrow (N=20, M=32) plus a CW=4
// instance for counter saturation and clear.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_signnarrow;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        valid, sat, iready, clr;
  logic [31:0] x;
  logic        ready, ovalid, ovf;
  logic [19:0] y;
  logic [15:0] cnt;

  logic        valid4, sat4, iready4, clr4;
  logic [31:0] x4;
  logic        ready4, ovalid4, ovf4;
  logic [19:0] y4;
  logic [3:0]  cnt4;

  int total = 0;
  int bad   = 0;

  signnarrow #(.N(20), .M(32), .CW(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_x(x),
    .i_sat(sat), .o_valid(ovalid), .i_ready(iready), .o_y(y), .o_ovf(ovf),
    .i_clr_cnt(clr), .o_ovf_cnt(cnt)
  );

  signnarrow #(.N(20), .M(32), .CW(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid4), .o_ready(ready4), .i_x(x4),
    .i_sat(sat4), .o_valid(ovalid4), .i_ready(iready4), .o_y(y4), .o_ovf(ovf4),
    .i_clr_cnt(clr4), .o_ovf_cnt(cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference narrowing by numeric range, packed as {ovf, y}
  function automatic logic [20:0] mdl(input logic [31:0] xv, input logic s);
    logic signed [31:0] v;
    v = xv;
    if (v > 32'sd524287)       return {1'b1, s ? 20'h7FFFF : xv[19:0]};
    else if (v < -32'sd524288) return {1'b1, s ? 20'h80000 : xv[19:0]};
    else                       return {1'b0, xv[19:0]};
  endfunction

  logic [20:0] q[$];
  logic [20:0] m;
  logic [20:0] f;
  int          exp_cnt;
  logic        acc, xfer;

  initial begin
    valid = 0; sat = 0; iready = 1; clr = 0; x = '0;
    valid4 = 0; sat4 = 0; iready4 = 1; clr4 = 0; x4 = '0;
    #12;
    chk("rst_valid", {31'd0, ovalid}, 0);
    chk("rst_ready", {31'd0, ready}, 1);
    chk("rst_y", {12'd0, y}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_cnt", {16'd0, cnt}, 0);
    rst = 0;

    // In-range values, both signs
    valid = 1; sat = 0; x = 32'h0007FFFF;
    step();
    chk("fit_pos_v", {31'd0, ovalid}, 1);
    chk("fit_pos_y", {12'd0, y}, 32'h7FFFF);
    chk("fit_pos_ovf", {31'd0, ovf}, 0);
    x = 32'hFFF80000;
    step();
    chk("fit_neg_y", {12'd0, y}, 32'h80000);
    chk("fit_neg_ovf", {31'd0, ovf}, 0);
    x = 32'hFFFFFFFF;
    step();
    chk("fit_m1_y", {12'd0, y}, 32'hFFFFF);
    chk("fit_m1_ovf", {31'd0, ovf}, 0);
    valid = 0;
    step();
    chk("fit_idle_v", {31'd0, ovalid}, 0);
    chk("fit_cnt", {16'd0, cnt}, 0);

    // Saturation
    valid = 1; sat = 1; x = 32'h00080000;
    step();
    chk("sat_pos_y", {12'd0, y}, 32'h7FFFF);
    chk("sat_pos_ovf", {31'd0, ovf}, 1);
    x = 32'hFFF7FFFF;
    step();
    chk("sat_neg_y", {12'd0, y}, 32'h80000);
    chk("sat_neg_ovf", {31'd0, ovf}, 1);
    chk("sat_cnt", {16'd0, cnt}, 2);

    // Wrap
    sat = 0; x = 32'h00080000;
    step();
    chk("wrap_a_y", {12'd0, y}, 32'h80000);
    chk("wrap_a_ovf", {31'd0, ovf}, 1);
    x = 32'h12345678;
    step();
    chk("wrap_b_y", {12'd0, y}, 32'h45678);
    chk("wrap_b_ovf", {31'd0, ovf}, 1);
    valid = 0;
    step();
    chk("wrap_cnt", {16'd0, cnt}, 4);
    chk("wrap_idle_v", {31'd0, ovalid}, 0);

    // Backpressure: 0 lands in main, 1 in skid, then 3 stalled edges
    valid = 1; x = 0;
    step();
    chk("bp_y0", {12'd0, y}, 0);
    x = 1; iready = 0;
    step();
    chk("bp_ready_lo", {31'd0, ready}, 0);
    chk("bp_hold1", {12'd0, y}, 0);
    x = 2;
    step();
    chk("bp_hold2", {12'd0, y}, 0);
    chk("bp_hold2_v", {31'd0, ovalid}, 1);
    step();
    chk("bp_hold3", {12'd0, y}, 0);
    chk("bp_ready_lo3", {31'd0, ready}, 0);
    iready = 1;
    step();
    chk("bp_y1", {12'd0, y}, 1);
    chk("bp_ready_hi", {31'd0, ready}, 1);
    step();
    chk("bp_y2", {12'd0, y}, 2);
    x = 3;
    step();
    chk("bp_y3", {12'd0, y}, 3);
    valid = 0;
    step();
    chk("bp_drain_v", {31'd0, ovalid}, 0);
    chk("bp_cnt", {16'd0, cnt}, 4);

    // Pseudo-random handshakes against a reference queue
    exp_cnt = 4;
    for (int i = 0; i < 300; i++) begin
      valid  = ($urandom_range(0, 3) != 0);
      iready = ($urandom_range(0, 2) != 0);
      sat    = $urandom_range(0, 1);
      case ($urandom_range(0, 4))
        0: x = $urandom;
        1: x = $urandom_range(0, 524287);
        2: x = -$urandom_range(1, 524288);
        3: x = 32'h00080000;
        default: x = 32'hFFF7FFFF;
      endcase
      acc  = valid & ready;
      xfer = ovalid & iready;
      m    = mdl(x, sat);
      if (xfer) begin
        if (q.size() == 0) chk("rnd_spurious", 1, 0);
        else begin
          f = q.pop_front();
          chk("rnd_y", {12'd0, y}, {12'd0, f[19:0]});
          chk("rnd_ovf", {31'd0, ovf}, {31'd0, f[20]});
        end
      end
      step();
      if (acc) begin
        q.push_back(m);
        if (m[20]) exp_cnt++;
      end
      chk("rnd_valid", {31'd0, ovalid}, {31'd0, q.size() > 0});
      chk("rnd_ready", {31'd0, ready}, {31'd0, q.size() < 2});
    end
    chk("rnd_cnt", {16'd0, cnt}, exp_cnt);
    valid = 0; iready = 1;
    step(); step(); step();
    q.delete();
    chk("rnd_drained", {31'd0, ovalid}, 0);

    // CW=4 instance: saturating count and clear priority
    valid4 = 1; sat4 = 1; x4 = 32'h00080000;
    for (int i = 0; i < 14; i++) step();
    chk("c4_cnt14", {28'd0, cnt4}, 14);
    step();
    chk("c4_cnt15", {28'd0, cnt4}, 15);
    for (int i = 0; i < 5; i++) step();
    chk("c4_hold15", {28'd0, cnt4}, 15);
    chk("c4_y", {12'd0, y4}, 32'h7FFFF);
    clr4 = 1;
    step();
    chk("c4_clr", {28'd0, cnt4}, 0);
    clr4 = 0;
    step();
    chk("c4_after_clr", {28'd0, cnt4}, 1);
    valid4 = 0;
    step();

    // Async reset with both entries occupied, asserted between edges
    valid = 1; sat = 0; iready = 0; x = 32'h11;
    step();
    x = 32'h22;
    step();
    chk("ar_full_ready", {31'd0, ready}, 0);
    valid = 0;
    #3;
    rst = 1;
    #1;
    chk("ar_valid", {31'd0, ovalid}, 0);
    chk("ar_ready", {31'd0, ready}, 1);
    chk("ar_cnt", {16'd0, cnt}, 0);
    chk("ar_y", {12'd0, y}, 0);
    #2;
    rst = 0;
    iready = 1;
    step();
    chk("ar_nostale1", {31'd0, ovalid}, 0);
    step();
    chk("ar_nostale2", {31'd0, ovalid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
